// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell stepped LSB-first, one bit per clock,
// with valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry;
    logic [CW-1:0]    bit_cnt;
    logic             fa_s;
    logic             fa_c;

    always_comb begin
        fa_s = a_sh[0] ^ b_sh[0] ^ carry;
        fa_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    end

    // New sum bit enters at the MSB so that after WIDTH steps bit 0 holds the first-computed bit.
    always_comb begin
        sum_nxt            = sum_sh >> 1;
        sum_nxt[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath only moves on accept and during RUN, so DONE holds the result stable for the sink.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh    <= a_in;
                        b_sh    <= b_in;
                        carry   <= cin;
                        bit_cnt <= '0;
                    end
                end
                RUN: begin
                    carry   <= fa_c;
                    sum_sh  <= sum_nxt;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign sum_out = sum_sh;
    assign cout    = carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=4 directed/random tests plus exhaustive
// WIDTH=1 and WIDTH=2 streams with random sink stalls, all checked against a+b+cin.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic       iv4, ir4, ci4, ov4, or4, co4, bz4;
    logic [3:0] a4, b4, s4;
    logic       iv2, ir2, ci2, ov2, or2, co2, bz2;
    logic [1:0] a2, b2, s2;
    logic       iv1, ir1, ci1, ov1, or1, co1, bz1;
    logic [0:0] a1, b1, s1;

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a_in(a4), .b_in(b4), .cin(ci4),
        .out_valid(ov4), .out_ready(or4), .sum_out(s4), .cout(co4), .busy(bz4)
    );
    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a_in(a2), .b_in(b2), .cin(ci2),
        .out_valid(ov2), .out_ready(or2), .sum_out(s2), .cout(co2), .busy(bz2)
    );
    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a_in(a1), .b_in(b1), .cin(ci1),
        .out_valid(ov1), .out_ready(or1), .sum_out(s1), .cout(co1), .busy(bz1)
    );

    // Presents one operand set to the WIDTH=4 unit and waits (bounded) for out_valid.
    task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic c,
                           output logic [4:0] res, output int lat, output int busycnt);
        a4 = a; b4 = b; ci4 = c; iv4 = 1'b1; or4 = 1'b0;
        @(posedge clk); #1;
        iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
        lat = 0; busycnt = 0;
        while (!ov4 && lat < 20) begin
            if (bz4) busycnt++;
            @(posedge clk); #1;
            lat++;
        end
        res = {co4, s4};
    endtask

    task automatic release4();
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv4 = 0; a4 = 0; b4 = 0; ci4 = 0; or4 = 0;
        iv2 = 0; a2 = 0; b2 = 0; ci2 = 0; or2 = 0;
        iv1 = 0; a1 = 0; b1 = 0; ci1 = 0; or1 = 0;
        #12;
        checks++;
        if ({ir4, ov4, bz4, s4, co4} !== {1'b1, 1'b0, 1'b0, 4'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset4 got ir=%b ov=%b busy=%b sum=%b cout=%b exp ir=1 ov=0 busy=0 sum=0000 cout=0",
                     ir4, ov4, bz4, s4, co4);
        end
        checks++;
        if ({ir2, ov2, bz2, ir1, ov1, bz1} !== 6'b100100) begin
            errors++;
            $display("[TB] FAIL reset_small got w2 ir/ov/busy=%b%b%b w1=%b%b%b exp 100 100",
                     ir2, ov2, bz2, ir1, ov1, bz1);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ir4, ov4, bz4} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL post_reset got ir/ov/busy=%b%b%b exp 100", ir4, ov4, bz4);
        end
    endtask

    task automatic test_directed();
        logic [3:0] ta[3]   = '{4'b0101, 4'b1111, 4'b1111};
        logic [3:0] tb[3]   = '{4'b0011, 4'b0001, 4'b1111};
        logic       tc[3]   = '{1'b0, 1'b0, 1'b1};
        logic [4:0] texp[3] = '{5'b01000, 5'b10000, 5'b11111};
        logic [4:0] res;
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_op4(ta[i], tb[i], tc[i], res, lat, bc);
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("[TB] FAIL latency case%0d got=%0d exp=4", i, lat);
            end
            checks++;
            if (bc !== 4) begin
                errors++;
                $display("[TB] FAIL busy_cycles case%0d got=%0d exp=4", i, bc);
            end
            checks++;
            if (res !== texp[i]) begin
                errors++;
                $display("[TB] FAIL result case%0d got=%b exp=%b", i, res, texp[i]);
            end
            release4();
            checks++;
            if ({ir4, ov4, bz4} !== 3'b100) begin
                errors++;
                $display("[TB] FAIL to_idle case%0d got ir/ov/busy=%b%b%b exp 100", i, ir4, ov4, bz4);
            end
        end
    endtask

    task automatic test_hold();
        logic [4:0] res;
        int lat, bc;
        run_op4(4'b0110, 4'b0001, 1'b0, res, lat, bc);
        checks++;
        if (res !== 5'b00111) begin
            errors++;
            $display("[TB] FAIL hold_result got=%b exp=00111", res);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                iv4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111; ci4 = 1'b1;
            end
            @(posedge clk); #1;
            iv4 = 1'b0;
            checks++;
            if ({ov4, ir4, co4, s4} !== {1'b1, 1'b0, 1'b0, 4'b0111}) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d got ov=%b ir=%b cout=%b sum=%b exp ov=1 ir=0 cout=0 sum=0111",
                         i, ov4, ir4, co4, s4);
            end
        end
        release4();
        checks++;
        if ({ir4, ov4} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL hold_release got ir/ov=%b%b exp 10", ir4, ov4);
        end
        run_op4(4'b0001, 4'b0001, 1'b0, res, lat, bc);
        checks++;
        if (res !== 5'b00010 || lat !== 4) begin
            errors++;
            $display("[TB] FAIL after_hold got=%b lat=%0d exp=00010 lat=4", res, lat);
        end
        release4();
    endtask

    task automatic test_reset_abort();
        logic [4:0] res;
        int lat, bc;
        a4 = 4'b1010; b4 = 4'b0101; ci4 = 1'b0; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({ov4, s4, co4, ir4, bz4} !== {1'b0, 4'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_abort got ov=%b sum=%b cout=%b ir=%b busy=%b exp ov=0 sum=0000 cout=0 ir=1 busy=0",
                     ov4, s4, co4, ir4, bz4);
        end
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ir4, ov4} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL abort_idle got ir/ov=%b%b exp 10", ir4, ov4);
        end
        run_op4(4'b0010, 4'b0010, 1'b0, res, lat, bc);
        checks++;
        if (res !== 5'b00100 || lat !== 4) begin
            errors++;
            $display("[TB] FAIL after_abort got=%b lat=%0d exp=00100 lat=4", res, lat);
        end
        release4();
    endtask

    task automatic test_random4();
        logic [3:0] a, b;
        logic       c;
        logic [4:0] res, expv;
        int lat, bc, stall;
        for (int n = 0; n < 16; n++) begin
            a = 4'($urandom); b = 4'($urandom); c = 1'($urandom);
            expv = 5'(a) + 5'(b) + 5'(c);
            run_op4(a, b, c, res, lat, bc);
            checks++;
            if (res !== expv || lat !== 4) begin
                errors++;
                $display("[TB] FAIL random4 a=%b b=%b c=%b got=%b lat=%0d exp=%b lat=4", a, b, c, res, lat, expv);
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                checks++;
                if (!ov4 || {co4, s4} !== expv) begin
                    errors++;
                    $display("[TB] FAIL random4_stall ov=%b got=%b exp=%b", ov4, {co4, s4}, expv);
                end
            end
            release4();
        end
    endtask

    // Operands always offered and sink always ready: accepts must come every WIDTH+2 cycles.
    task automatic test_back_to_back();
        logic [4:0] q[$];
        logic [4:0] expv;
        logic [3:0] ca, cb;
        logic       cc, acc, hand;
        int cyc, last_acc, n_sent, n_got;
        cyc = 0; last_acc = -1; n_sent = 0; n_got = 0;
        ca = 4'($urandom); cb = 4'($urandom); cc = 1'($urandom);
        a4 = ca; b4 = cb; ci4 = cc; iv4 = 1'b1; or4 = 1'b1;
        while (n_got < 6 && cyc < 200) begin
            acc  = iv4 && ir4;
            hand = ov4 && or4;
            if (hand) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL b2b_extra got=%b exp=no result", {co4, s4});
                end else begin
                    expv = q.pop_front();
                    if ({co4, s4} !== expv) begin
                        errors++;
                        $display("[TB] FAIL b2b_result got=%b exp=%b", {co4, s4}, expv);
                    end
                end
                n_got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                q.push_back(5'(ca) + 5'(cb) + 5'(cc));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== 6) begin
                        errors++;
                        $display("[TB] FAIL b2b_spacing got=%0d exp=6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                n_sent++;
                ca = 4'($urandom); cb = 4'($urandom); cc = 1'($urandom);
                a4 = ca; b4 = cb; ci4 = cc;
                if (n_sent >= 6) iv4 = 1'b0;
            end
        end
        iv4 = 1'b0; or4 = 1'b0;
        checks++;
        if (n_got !== 6 || q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_count got=%0d pending=%0d exp=6 pending=0", n_got, q.size());
        end
    endtask

    task automatic test_exhaustive_w2();
        logic [2:0] q[$];
        logic [2:0] expv, heldv;
        logic [1:0] ca, cb;
        logic       cc, acc, hand, held;
        int cyc, n_sent, n_got;
        cyc = 0; n_sent = 0; n_got = 0; held = 1'b0; heldv = '0;
        ca = '0; cb = '0; cc = 1'b0;
        while (n_got < 32 && cyc < 2000) begin
            if (!iv2 && n_sent < 32 && $urandom_range(0, 3) != 0) begin
                ca = 2'(n_sent); cb = 2'(n_sent >> 2); cc = 1'(n_sent >> 4);
                a2 = ca; b2 = cb; ci2 = cc; iv2 = 1'b1;
            end
            or2  = 1'($urandom_range(0, 1));
            acc  = iv2 && ir2;
            hand = ov2 && or2;
            if (hand) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL w2_extra got=%b exp=no result", {co2, s2});
                end else begin
                    expv = q.pop_front();
                    if ({co2, s2} !== expv) begin
                        errors++;
                        $display("[TB] FAIL w2_result got=%b exp=%b", {co2, s2}, expv);
                    end
                end
                n_got++;
            end
            held  = ov2 && !or2;
            heldv = {co2, s2};
            @(posedge clk); #1;
            cyc++;
            if (held) begin
                checks++;
                if (!ov2 || {co2, s2} !== heldv) begin
                    errors++;
                    $display("[TB] FAIL w2_stall ov=%b got=%b exp=%b", ov2, {co2, s2}, heldv);
                end
            end
            if (acc) begin
                q.push_back(3'(ca) + 3'(cb) + 3'(cc));
                n_sent++;
                iv2 = 1'b0;
                a2 = 2'($urandom); b2 = 2'($urandom); ci2 = 1'($urandom);
            end
        end
        or2 = 1'b0;
        checks++;
        if (n_got !== 32 || q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL w2_count got=%0d pending=%0d exp=32 pending=0", n_got, q.size());
        end
    endtask

    task automatic test_exhaustive_w1();
        logic [1:0] q[$];
        logic [1:0] expv, heldv;
        logic       ca, cb, cc, acc, hand, held;
        int cyc, n_sent, n_got, lastacc;
        cyc = 0; n_sent = 0; n_got = 0; held = 1'b0; heldv = '0; lastacc = 0;
        ca = 1'b0; cb = 1'b0; cc = 1'b0;
        while (n_got < 8 && cyc < 1000) begin
            if (!iv1 && n_sent < 8 && $urandom_range(0, 3) != 0) begin
                ca = 1'(n_sent); cb = 1'(n_sent >> 1); cc = 1'(n_sent >> 2);
                a1 = ca; b1 = cb; ci1 = cc; iv1 = 1'b1;
            end
            or1  = 1'($urandom_range(0, 1));
            acc  = iv1 && ir1;
            hand = ov1 && or1;
            if (hand) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL w1_extra got=%b exp=no result", {co1, s1});
                end else begin
                    expv = q.pop_front();
                    if ({co1, s1} !== expv) begin
                        errors++;
                        $display("[TB] FAIL w1_result got=%b exp=%b", {co1, s1}, expv);
                    end
                end
                n_got++;
            end
            held  = ov1 && !or1;
            heldv = {co1, s1};
            @(posedge clk); #1;
            cyc++;
            if (held) begin
                checks++;
                if (!ov1 || {co1, s1} !== heldv) begin
                    errors++;
                    $display("[TB] FAIL w1_stall ov=%b got=%b exp=%b", ov1, {co1, s1}, heldv);
                end
            end
            if (acc) begin
                q.push_back(2'(ca) + 2'(cb) + 2'(cc));
                n_sent++;
                lastacc = cyc;
                iv1 = 1'b0;
                a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
            end
            if (cyc == lastacc + 1 && n_sent > 0 && bz1) begin
                checks++;
                errors++;
                $display("[TB] FAIL w1_run_length got busy=1 exp busy=0 one cycle after accept");
            end
        end
        or1 = 1'b0;
        checks++;
        if (n_got !== 8 || q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL w1_count got=%0d pending=%0d exp=8 pending=0", n_got, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_abort();
        test_random4();
        test_back_to_back();
        test_exhaustive_w2();
        test_exhaustive_w1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
